// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage. It selects the next PC from trap,
// redirect (live or buffered), stall hold and sequential increment, and drives the fetch request.
module pc_gen #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                INC          = 4,
    parameter int                ALIGN_BITS   = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic            fetch_ready_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_seq_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] misaligned_addr_o
);

    localparam logic [XLEN-1:0] INC_V    = XLEN'(INC);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [XLEN-1:0] r_pc;
    logic            r_run;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_misaligned;
    logic [XLEN-1:0] r_misaligned_addr;

    logic [XLEN-1:0] w_target;
    logic            w_target_bad;
    logic            w_handshake;
    logic            w_apply_redirect;

    // A live redirect is newer than the buffered one, so it takes precedence.
    assign w_target         = redirect_valid_i ? redirect_pc_i : r_pend_pc;
    assign w_target_bad     = |(w_target & LOW_MASK);
    assign w_apply_redirect = ~stall_i & (redirect_valid_i | r_pend_valid);
    assign w_handshake      = fetch_valid_o & fetch_ready_i;

    assign fetch_valid_o     = r_run & ~stall_i;
    assign pc_o              = r_pc;
    assign pc_next_seq_o     = r_pc + INC_V;
    assign misaligned_o      = r_misaligned;
    assign misaligned_addr_o = r_misaligned_addr;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_pc              <= RESET_VECTOR;
            r_run             <= 1'b0;
            r_pend_valid      <= 1'b0;
            r_pend_pc         <= '0;
            r_misaligned      <= 1'b0;
            r_misaligned_addr <= '0;
        end else begin
            r_run        <= 1'b1;
            r_misaligned <= 1'b0;
            if (trap_i) begin
                r_pc         <= trap_vector_i & ~LOW_MASK;
                r_pend_valid <= 1'b0;
            end else if (w_apply_redirect) begin
                // Flush: applied regardless of fetch_ready_i.
                if (w_target_bad) begin
                    r_misaligned      <= 1'b1;
                    r_misaligned_addr <= w_target;
                end else begin
                    r_pc <= w_target;
                end
                r_pend_valid <= 1'b0;
            end else if (stall_i && redirect_valid_i) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= redirect_pc_i;
            end else if (w_handshake) begin
                r_pc <= r_pc + INC_V;
            end
        end
    end

endmodule
